gf_inv_sbox_iter: RTL and testbench

//  Parametrised iterative GF(2^W) multiplicative inverter with optional AES affine stages.

---
 rtl/gf_inv_sbox_iter_if.sv | 13 +
 rtl/gf_inv_sbox_iter.sv | 106 ++++++++++
 tb/tb_gf_inv_sbox_iter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/gf_inv_sbox_iter_if.sv
// gf_inv_sbox_iter_if: request/response bundle for the iterative GF(2^W) inverter / AES S-box.
interface gf_inv_sbox_iter_if #(parameter int W = 8);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   mode;
    logic [W-1:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic         busy;
    modport master (output in_valid, mode, data_in, out_ready, input in_ready, out_valid, data_out, busy);
    modport slave  (input in_valid, mode, data_in, out_ready, output in_ready, out_valid, data_out, busy);
endinterface

// File: rtl/gf_inv_sbox_iter.sv
// gf_inv_sbox_iter: bit-serial extended-Euclid GF(2^W) inverter with optional AES affine stages.
module gf_inv_sbox_iter #(
    parameter int         W         = 8,
    parameter logic [W:0] POLY      = 9'h11B,
    parameter bit         AFFINE_EN = 1'b1
) (
    input logic clk,
    input logic reset,
    gf_inv_sbox_iter_if.slave bus
);
    if ((AFFINE_EN && W != 8) || !POLY[W]) begin : g_param_err
        $error("gf_inv_sbox_iter: AFFINE_EN needs W==8 and POLY[W] must be set");
    end

    typedef enum logic [2:0] {IDLE, PRE, EUC, POST, DONE} state_t;

    function automatic logic [4:0] deg(input logic [W:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i <= W; i++) if (v[i]) r = 5'(i);
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8];
        return r ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[(i+2)%8] ^ b[(i+5)%8] ^ b[(i+7)%8];
        return r ^ 8'h05;
    endfunction

    state_t       st;
    logic [1:0]   md;
    logic [W-1:0] a_in, a_pre, inv;
    logic [W:0]   rp, rc, tp, tc, rp_n, tp_n, rp_x, rc_x, tp_x, tc_x;
    logic [4:0]   d;
    logic         sw;

    assign a_pre = (md == 2'b01) ? W'(inv_affine(8'(a_in))) : a_in;

    // one shift-subtract step, swapping so r_prev always holds the higher-degree remainder
    always_comb begin
        d    = deg(rp) - deg(rc);
        rp_n = rp ^ (rc << d);
        tp_n = tp ^ (tc << d);
        sw   = deg(rp_n) < deg(rc);
        rp_x = sw ? rc : rp_n;
        tp_x = sw ? tc : tp_n;
        rc_x = sw ? rp_n : rc;
        tc_x = sw ? tp_n : tc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st            <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
            bus.busy      <= 1'b0;
        end else begin
            case (st)
                IDLE: if (bus.in_valid && bus.in_ready) begin
                    md           <= AFFINE_EN ? bus.mode : 2'b10;
                    a_in         <= bus.data_in;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b1;
                    st           <= PRE;
                end
                PRE: begin
                    rp  <= POLY;
                    rc  <= {1'b0, a_pre};
                    tp  <= '0;
                    tc  <= {{W{1'b0}}, 1'b1};
                    inv <= a_pre;
                    st  <= (a_pre == '0 || a_pre == {{(W-1){1'b0}}, 1'b1}) ? POST : EUC;
                end
                EUC: begin
                    rp <= rp_x;
                    rc <= rc_x;
                    tp <= tp_x;
                    tc <= tc_x;
                    if (rc_x == {{W{1'b0}}, 1'b1}) begin
                        inv <= tc_x[W-1:0];
                        st  <= POST;
                    end
                end
                POST: begin
                    bus.data_out  <= (md == 2'b00) ? W'(affine(8'(inv))) : inv;
                    bus.out_valid <= 1'b1;
                    st            <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    bus.busy      <= 1'b0;
                    st            <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gf_inv_sbox_iter.sv
// tb_gf_inv_sbox_iter: scoreboard bench for the AES-sized instance and a W=4 raw-inverse instance.
module tb_gf_inv_sbox_iter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gf_inv_sbox_iter_if #(.W(8)) b8();
    gf_inv_sbox_iter_if #(.W(4)) b4();
    gf_inv_sbox_iter #(.W(8), .POLY(9'h11B), .AFFINE_EN(1'b1)) dut8 (.clk(clk), .reset(reset), .bus(b8));
    gf_inv_sbox_iter #(.W(4), .POLY(5'h13), .AFFINE_EN(1'b0)) dut4 (.clk(clk), .reset(reset), .bus(b4));

    int checks = 0;
    int errors = 0;
    logic [7:0] q8[$];
    logic [3:0] q4[$];
    logic [7:0] dv[9] = '{8'h00, 8'h01, 8'h53, 8'hFF, 8'hED, 8'h63, 8'h7C, 8'h53, 8'h02};
    logic [1:0] dm[9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    logic [7:0] de[9] = '{8'h63, 8'h7C, 8'hED, 8'h16, 8'h53, 8'h00, 8'h01, 8'hCA, 8'h8D};

    // polynomial product modulo poly, schoolbook shift-and-reduce
    function automatic logic [15:0] gmul(input logic [15:0] a, input logic [15:0] b, input int w, input logic [16:0] poly);
        logic [16:0] r;
        r = '0;
        for (int i = w - 1; i >= 0; i--) begin
            r = r << 1;
            if (r[w]) r = r ^ poly;
            if (b[i]) r = r ^ {1'b0, a};
        end
        return r[15:0];
    endfunction

    function automatic logic [15:0] ginv(input logic [15:0] x, input int w, input logic [16:0] poly);
        for (int y = 1; y < (1 << w); y++) if (gmul(x, 16'(y), w, poly) == 16'd1) return 16'(y);
        return 16'd0;
    endfunction

    function automatic logic [7:0] aff(input logic [7:0] b);
        logic [7:0] c, r;
        c = 8'h63;
        for (int i = 0; i < 8; i++) r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
        return r;
    endfunction

    function automatic logic [7:0] invaff(input logic [7:0] b);
        logic [7:0] c, r;
        c = 8'h05;
        for (int i = 0; i < 8; i++) r[i] = b[(i+2)%8] ^ b[(i+5)%8] ^ b[(i+7)%8] ^ c[i];
        return r;
    endfunction

    function automatic logic [7:0] inv8(input logic [7:0] x);
        return 8'(ginv(16'(x), 8, 17'h11B));
    endfunction

    function automatic logic [7:0] exp8(input logic [7:0] x, input logic [1:0] m);
        return (m == 2'd0) ? aff(inv8(x)) : (m == 2'd1) ? inv8(invaff(x)) : inv8(x);
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    always @(negedge clk) if (!reset && b8.out_valid && b8.out_ready) begin
        checks++;
        if (q8.size() == 0) begin
            errors++;
            $display("FAIL out8_unexpected got=%h want=none", b8.data_out);
        end else begin
            if (b8.data_out !== q8[0]) begin
                errors++;
                $display("FAIL out8 got=%h want=%h", b8.data_out, q8[0]);
            end
            void'(q8.pop_front());
        end
    end

    always @(negedge clk) if (!reset && b4.out_valid && b4.out_ready) begin
        checks++;
        if (q4.size() == 0) begin
            errors++;
            $display("FAIL out4_unexpected got=%h want=none", b4.data_out);
        end else begin
            if (b4.data_out !== q4[0]) begin
                errors++;
                $display("FAIL out4 got=%h want=%h", b4.data_out, q4[0]);
            end
            void'(q4.pop_front());
        end
    end

    task automatic req(input bit w4, input logic [7:0] d, input logic [1:0] m, input logic [7:0] e);
        int n = 0;
        @(posedge clk); #1;
        chk("in_ready_idle", 16'(w4 ? b4.in_ready : b8.in_ready), 16'd1);
        if (w4) begin
            b4.in_valid = 1'b1; b4.data_in = d[3:0]; b4.mode = m; q4.push_back(e[3:0]);
        end else begin
            b8.in_valid = 1'b1; b8.data_in = d; b8.mode = m; q8.push_back(e);
        end
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        b8.in_valid = 1'b0;
        while (!(w4 ? b4.out_valid : b8.out_valid) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n > (w4 ? 9 : 17)) begin
            errors++;
            $display("FAIL latency in=%h got=%0d want<=%0d", d, n, w4 ? 9 : 17);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] x, v;
        logic [1:0] m;
        int n;
        b8.in_valid = 0; b8.data_in = '0; b8.mode = '0; b8.out_ready = 1;
        b4.in_valid = 0; b4.data_in = '0; b4.mode = '0; b4.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 16'(b8.in_ready), 16'd1);
        chk("rst_out_valid", 16'(b8.out_valid), 16'd0);
        chk("rst_data_out", 16'(b8.data_out), 16'd0);
        chk("rst_busy", 16'(b8.busy), 16'd0);
        chk("rst4_in_ready", 16'(b4.in_ready), 16'd1);
        chk("rst4_out_valid", 16'(b4.out_valid), 16'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) req(1'b0, dv[i], dm[i], de[i]);
        repeat (60) begin
            x = 8'($urandom);
            m = 2'($urandom_range(0, 3));
            req(1'b0, x, m, exp8(x, m));
        end
        for (int i = 0; i < 256; i++) req(1'b0, 8'(i), 2'd2, inv8(8'(i)));

        @(posedge clk); #1;
        b8.out_ready = 0; b8.in_valid = 1; b8.data_in = 8'h53; b8.mode = 2'd0;
        q8.push_back(8'hED);
        @(posedge clk); #1;
        b8.in_valid = 0;
        n = 0;
        while (!b8.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_valid", 16'(b8.out_valid), 16'd1);
        v = b8.data_out;
        chk("bp_data", 16'(v), 16'h00ED);
        repeat (10) begin
            b8.in_valid = 1; b8.data_in = 8'h00; b8.mode = 2'd0;
            @(posedge clk); #1;
            chk("bp_hold_valid", 16'(b8.out_valid), 16'd1);
            chk("bp_hold_data", 16'(b8.data_out), 16'(v));
            chk("bp_in_ready", 16'(b8.in_ready), 16'd0);
        end
        b8.in_valid = 0; b8.out_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_ready", 16'(b8.in_ready), 16'd1);
        chk("bp_release_valid", 16'(b8.out_valid), 16'd0);

        @(posedge clk); #1;
        b8.in_valid = 1; b8.data_in = 8'h53; b8.mode = 2'd0;
        @(posedge clk); #1;
        b8.in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy", 16'(b8.busy), 16'd1);
        chk("mid_no_valid", 16'(b8.out_valid), 16'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_valid", 16'(b8.out_valid), 16'd0);
        chk("mid_rst_busy", 16'(b8.busy), 16'd0);
        chk("mid_rst_ready", 16'(b8.in_ready), 16'd1);
        reset = 1'b0;
        req(1'b0, 8'h01, 2'd0, 8'h7C);

        req(1'b1, 8'h02, 2'd0, 8'h09);
        req(1'b1, 8'h00, 2'd3, 8'h00);
        for (int i = 1; i < 16; i++) req(1'b1, 8'(i), 2'($urandom_range(0, 3)), 8'(ginv(16'(i), 4, 17'h13)));

        repeat (3) @(posedge clk);
        #1;
        chk("q8_drained", 16'(q8.size()), 16'd0);
        chk("q4_drained", 16'(q4.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
